// File: rtl/ctrl_fsm_pkg.sv
// Shared definitions for the ctrl_fsm control unit: state encoding, opcodes,
// immediate-format bit positions and the EBREAK word.
package ctrl_fsm_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam int unsigned FMT_R = 0;
   localparam int unsigned FMT_I = 1;
   localparam int unsigned FMT_S = 2;
   localparam int unsigned FMT_B = 3;
   localparam int unsigned FMT_U = 4;
   localparam int unsigned FMT_J = 5;
   localparam int unsigned FMT_W = 6;

   localparam logic [31:0] EBREAK = 32'h00100073;

   // Formats whose instructions produce a register-file result.
   function automatic logic writes_rd(input logic [FMT_W-1:0] fmt);
      return fmt[FMT_R] | fmt[FMT_I] | fmt[FMT_U] | fmt[FMT_J];
   endfunction

endpackage

// File: rtl/ctrl_opdec.sv
// Combinational opcode decoder: one-hot immediate format plus load/store/ebreak
// flags for the sequencer in ctrl_fsm.
module ctrl_opdec
   import ctrl_fsm_pkg::*;
(
   input  logic [31:0]      inst,
   output logic [FMT_W-1:0] format,
   output logic             is_load,
   output logic             is_store,
   output logic             is_ebreak
);

   logic [6:0] opcode;

   assign opcode = inst[6:0];

   always_comb begin
      format = '0;
      case (opcode)
         OP_OP:                                   format[FMT_R] = 1'b1;
         OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:     format[FMT_I] = 1'b1;
         OP_STORE:                                format[FMT_S] = 1'b1;
         OP_BRANCH:                               format[FMT_B] = 1'b1;
         OP_LUI, OP_AUIPC:                        format[FMT_U] = 1'b1;
         OP_JAL:                                  format[FMT_J] = 1'b1;
         default:                                 format = '0;
      endcase
   end

   assign is_load   = (opcode == OP_LOAD);
   assign is_store  = (opcode == OP_STORE);
   // EBREAK is identified by the whole word, not just its SYSTEM opcode.
   assign is_ebreak = (inst == EBREAK);

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> WB.
// Define CTRL_ILLEGAL_TRAP_EN to halt on opcodes that decode to no format.
module ctrl_fsm
   import ctrl_fsm_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_imem_ready,
   input  logic [31:0] i_imem_rdata,
   input  logic        i_dmem_ready,
   output logic        o_imem_req,
   output logic        o_dmem_req,
   output logic        o_dmem_wen,
   output logic [31:0] o_inst,
   output logic [5:0]  o_format,
   output logic        o_rf_we,
   output logic        o_pc_we,
   output logic        o_halt,
   output logic [2:0]  o_state
);

   state_t           state;
   state_t           state_next;
   logic [FMT_W-1:0] dec_format;
   logic             dec_load;
   logic             dec_store;
   logic             dec_ebreak;

   ctrl_opdec u_opdec (
      .inst      (o_inst),
      .format    (dec_format),
      .is_load   (dec_load),
      .is_store  (dec_store),
      .is_ebreak (dec_ebreak)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= ST_FETCH;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_inst   <= '0;
         o_format <= '0;
      end else begin
         if (state == ST_FETCH && i_imem_ready) begin
            o_inst <= i_imem_rdata;
         end
         if (state == ST_DECODE) begin
            o_format <= dec_format;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_FETCH:  if (i_imem_ready) state_next = ST_DECODE;
         ST_DECODE: state_next = ST_EXEC;
         ST_EXEC: begin
            if (dec_load || dec_store) begin
               state_next = ST_MEM;
            end else if (dec_ebreak) begin
               state_next = ST_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
            end else if (o_format == '0) begin
               state_next = ST_HALT;
`endif
            end else begin
               state_next = ST_WB;
            end
         end
         ST_MEM:    if (i_dmem_ready) state_next = ST_WB;
         ST_WB:     state_next = ST_FETCH;
         ST_HALT:   state_next = ST_HALT;
         default:   state_next = ST_FETCH;
      endcase
   end

   // The fetch request is masked while reset is held so all requests read 0.
   always_comb begin
      o_imem_req = (state == ST_FETCH) && !i_rst;
      o_dmem_req = (state == ST_MEM);
      o_dmem_wen = (state == ST_MEM) && dec_store;
      o_pc_we    = (state == ST_WB);
      o_rf_we    = (state == ST_WB) && writes_rd(o_format) && (o_inst[11:7] != 5'd0);
      o_halt     = (state == ST_HALT);
      o_state    = state;
   end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Randomized self-checking bench for ctrl_fsm against a transaction-level model.
module tb_ctrl_fsm;
   import ctrl_fsm_pkg::*;

`ifdef CTRL_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   localparam logic [5:0] E_IMEM = 6'b100000;
   localparam logic [5:0] E_DMEM = 6'b010000;
   localparam logic [5:0] E_WEN  = 6'b001000;
   localparam logic [5:0] E_RF   = 6'b000100;
   localparam logic [5:0] E_PC   = 6'b000010;
   localparam logic [5:0] E_HALT = 6'b000001;
   localparam int unsigned HALT_CYCLES = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        dmem_ready;
   logic        imem_req, dmem_req, dmem_wen, rf_we, pc_we, halt;
   logic [31:0] inst;
   logic [5:0]  format;
   logic [2:0]  state;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   logic [31:0] prev_inst;
   logic [5:0]  prev_fmt;

   always #5 clk = ~clk;

   ctrl_fsm dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_imem_ready (imem_ready),
      .i_imem_rdata (imem_rdata),
      .i_dmem_ready (dmem_ready),
      .o_imem_req   (imem_req),
      .o_dmem_req   (dmem_req),
      .o_dmem_wen   (dmem_wen),
      .o_inst       (inst),
      .o_format     (format),
      .o_rf_we      (rf_we),
      .o_pc_we      (pc_we),
      .o_halt       (halt),
      .o_state      (state)
   );

   function automatic logic [5:0] model_format(input logic [6:0] op);
      logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f};
      int         fidx [10] = '{0, 1, 1, 1, 1, 2, 3, 4, 4, 5};
      for (int i = 0; i < 10; i++) begin
         if (ops[i] == op) return 6'd1 << fidx[i];
      end
      return 6'd0;
   endfunction

   function automatic logic [5:0] outs();
      return {imem_req, dmem_req, dmem_wen, rf_we, pc_we, halt};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      prev_inst = '0;
      prev_fmt  = '0;
   endtask

   // Runs one instruction from its first FETCH cycle; leaves time at the
   // sample point of the cycle after WB (or after the observed HALT cycles).
   task automatic run_instr(input logic [31:0] word, input int unsigned idly,
                            input int unsigned ddly, output bit halted);
      logic [5:0]  exp_q[$];
      logic [5:0]  efmt;
      bit          is_mem, is_store, do_halt, do_rf;
      int unsigned mem_start, mem_end;
      efmt     = model_format(word[6:0]);
      is_store = (word[6:0] == 7'b0100011);
      is_mem   = is_store || (word[6:0] == 7'b0000011);
      do_halt  = !is_mem && ((word == 32'h00100073) || (TRAP && efmt == 6'd0));
      do_rf    = (efmt[0] | efmt[1] | efmt[4] | efmt[5]) && (word[11:7] != 5'd0);
      repeat (idly + 1) exp_q.push_back(E_IMEM);
      exp_q.push_back(6'd0);
      exp_q.push_back(6'd0);
      mem_start = idly + 3;
      mem_end   = mem_start + ddly;
      if (is_mem) repeat (ddly + 1) exp_q.push_back(E_DMEM | (is_store ? E_WEN : 6'd0));
      if (do_halt) repeat (HALT_CYCLES) exp_q.push_back(E_HALT);
      else exp_q.push_back(E_PC | (do_rf ? E_RF : 6'd0));
      for (int k = 0; k < exp_q.size(); k++) begin
         vectors++;
         if (outs() !== exp_q[k]) begin
            miscompares++;
            $display("FAIL strobes word=%h k=%0d got=%b exp=%b", word, k, outs(), exp_q[k]);
         end
         vectors++;
         if (inst !== ((k > idly) ? word : prev_inst)) begin
            miscompares++;
            $display("FAIL inst word=%h k=%0d got=%h exp=%h", word, k, inst,
                     (k > idly) ? word : prev_inst);
         end
         vectors++;
         if (format !== ((k > idly + 1) ? efmt : prev_fmt)) begin
            miscompares++;
            $display("FAIL format word=%h k=%0d got=%b exp=%b", word, k, format,
                     (k > idly + 1) ? efmt : prev_fmt);
         end
         if (k < idly) imem_ready = 1'b0;
         else if (k == idly) imem_ready = 1'b1;
         else imem_ready = 1'($urandom_range(0, 1));
         imem_rdata = (k == idly) ? word : $urandom;
         if (is_mem && k >= mem_start && k <= mem_end) dmem_ready = (k == mem_end);
         else dmem_ready = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
      end
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      prev_inst = word;
      prev_fmt  = efmt;
      halted    = do_halt;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      imem_rdata = 32'hDEADBEEF;
      @(posedge clk);
      #1;
      vectors++;
      if ({outs(), inst, format} !== '0) begin
         miscompares++;
         $display("FAIL reset_outs got=%b/%h/%b exp=0", outs(), inst, format);
      end
      vectors++;
      if (state !== ST_FETCH) begin
         miscompares++;
         $display("FAIL reset_state got=%0d exp=%0d", state, ST_FETCH);
      end
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if ({outs(), inst} !== '0) begin
         miscompares++;
         $display("FAIL reset_ready_ignored got=%b/%h exp=0", outs(), inst);
      end
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      vectors++;
      if (state !== ST_FETCH || outs() !== E_IMEM) begin
         miscompares++;
         $display("FAIL post_reset got=%0d/%b exp=%0d/%b", state, outs(), ST_FETCH, E_IMEM);
      end
      prev_inst = '0;
      prev_fmt  = '0;
   endtask

   task automatic test_addi();
      bit h;
      run_instr(32'h00500093, 0, 0, h);
   endtask

   task automatic test_store_wait();
      bit h;
      run_instr(32'h00112023, 0, 3, h);
      run_instr(32'h0000a183, 2, 1, h);
   endtask

   task automatic test_branch_and_x0();
      bit h;
      run_instr(32'h00208463, 1, 0, h);
      run_instr(32'h00000013, 0, 0, h);
   endtask

   task automatic test_illegal();
      bit h;
      run_instr(32'hFFFFFFFF, 0, 0, h);
      if (h) do_reset();
   endtask

   task automatic test_reset_mid_mem();
      imem_ready = 1'b1;
      imem_rdata = 32'h00112023;
      repeat (3) begin
         @(posedge clk);
         #1;
         imem_ready = 1'b0;
      end
      vectors++;
      if (outs() !== (E_DMEM | E_WEN)) begin
         miscompares++;
         $display("FAIL mid_mem_req got=%b exp=%b", outs(), E_DMEM | E_WEN);
      end
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({outs(), inst, format} !== '0 || state !== ST_FETCH) begin
         miscompares++;
         $display("FAIL mid_mem_reset got=%b/%h/%b/%0d exp=0/FETCH", outs(), inst, format, state);
      end
      dmem_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      vectors++;
      if (outs() !== E_IMEM || state !== ST_FETCH) begin
         miscompares++;
         $display("FAIL mid_mem_release got=%b/%0d exp=%b/%0d", outs(), state, E_IMEM, ST_FETCH);
      end
      dmem_ready = 1'b0;
      prev_inst = '0;
      prev_fmt  = '0;
   endtask

   task automatic test_ebreak();
      bit h;
      run_instr(32'h00100073, 1, 0, h);
      vectors++;
      if (h !== 1'b1 || halt !== 1'b1) begin
         miscompares++;
         $display("FAIL ebreak_halt got=%b exp=1", halt);
      end
      do_reset();
   endtask

   task automatic test_random();
      bit          h;
      logic [31:0] w;
      logic [6:0]  ops [11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37,
                                7'h17, 7'h6f, 7'h7f};
      for (int n = 0; n < 60; n++) begin
         w = $urandom;
         if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 10)];
         if ($urandom_range(0, 15) == 0) w = 32'h00100073;
         run_instr(w, $urandom_range(0, 3), $urandom_range(0, 4), h);
         if (h) do_reset();
      end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_store_wait();
      test_branch_and_x0();
      test_illegal();
      test_reset_mid_mem();
      test_addi();
      test_ebreak();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
